// File: rtl/m_axis_packet_tx.sv
// m_axis_packet_tx
//
// Egress packet buffer for the outbound AXI4-Stream link. Forwarding logic
// writes one packet byte by byte (FILL), then commits it. The packet is then
// streamed out as 32-bit little-endian beats (SEND), and the block returns to
// FILL once the last beat has been accepted. Holds exactly one packet.
//
// Ports:
//   aclk, aresetn      clock, asynchronous active-low reset
//   wr_en, wr_data     byte write into the packet being assembled
//   commit             packet complete, start transmission
//   abort              drop the partially written packet
//   ready              FILL and buffer not full
//   overflow           one-cycle pulse after a write was dropped (buffer full)
//   data_len           bytes currently buffered
//   m_axis_*           AXI4-Stream master (tdata, tkeep, tvalid, tlast, tready)

module m_axis_packet_tx #(
    parameter int FIFO_SIZE = 1024,
    parameter int LEN_WIDTH = 16
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 wr_en,
    input  logic [7:0]           wr_data,
    input  logic                 commit,
    input  logic                 abort,
    output logic                 ready,
    output logic                 overflow,
    output logic [LEN_WIDTH-1:0] data_len,
    output logic [31:0]          m_axis_tdata,
    output logic [3:0]           m_axis_tkeep,
    output logic                 m_axis_tvalid,
    output logic                 m_axis_tlast,
    input  logic                 m_axis_tready
);

    localparam int AW = (FIFO_SIZE > 1) ? $clog2(FIFO_SIZE) : 1;
    localparam logic [LEN_WIDTH:0] SIZE_EXT = (LEN_WIDTH+1)'(FIFO_SIZE);

    typedef enum logic {
        FILL = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic                 ovf_q, ovf_d;

    logic [7:0]           mem [FIFO_SIZE];

    // Length/pointer comparisons are done one bit wider so rd_ptr+4 can never
    // wrap around when the packet fills the whole buffer.
    logic [LEN_WIDTH:0]   len_ext, ptr_ext;
    logic [LEN_WIDTH:0]   lane_addr [4];
    logic                 wr_ok;
    logic                 last_beat;

    assign len_ext   = {1'b0, len_q};
    assign ptr_ext   = {1'b0, rd_ptr_q};
    assign last_beat = (ptr_ext + (LEN_WIDTH+1)'(4)) >= len_ext;
    assign wr_ok     = (state_q == FILL) && !abort && wr_en && (len_ext < SIZE_EXT);

    // Byte storage: no reset needed, contents beyond data_len are never exposed.
    always_ff @(posedge aclk) begin
        if (wr_ok) begin
            mem[len_q[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= FILL;
            len_q    <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = 1'b0;
        case (state_q)
            FILL: begin
                if (abort) begin
                    len_d = '0;
                end else begin
                    if (wr_ok) begin
                        len_d = len_q + LEN_WIDTH'(1);
                    end else if (wr_en) begin
                        ovf_d = 1'b1;
                    end
                    // A byte written in the commit cycle belongs to the packet,
                    // so an empty buffer plus that byte is still a valid commit.
                    if (commit && (wr_ok || (len_q != '0))) begin
                        state_d  = SEND;
                        rd_ptr_d = '0;
                    end
                end
            end
            SEND: begin
                if (m_axis_tready) begin
                    if (last_beat) begin
                        state_d  = FILL;
                        len_d    = '0;
                        rd_ptr_d = '0;
                    end else begin
                        rd_ptr_d = rd_ptr_q + LEN_WIDTH'(4);
                    end
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // Beat assembly: a lane is live only if its address lies inside the packet.
    // This reproduces tkeep=1111 on inner beats and the contiguous partial mask
    // on the last beat, and zeroes lanes holding stale buffer bytes.
    always_comb begin
        m_axis_tdata = '0;
        m_axis_tkeep = '0;
        for (int i = 0; i < 4; i++) begin
            lane_addr[i] = ptr_ext + (LEN_WIDTH+1)'(i);
            if ((state_q == SEND) && (lane_addr[i] < len_ext)) begin
                m_axis_tkeep[i]       = 1'b1;
                m_axis_tdata[8*i +: 8] = mem[lane_addr[i][AW-1:0]];
            end
        end
    end

    assign m_axis_tvalid = (state_q == SEND);
    assign m_axis_tlast  = (state_q == SEND) && last_beat;
    assign ready         = (state_q == FILL) && (len_ext < SIZE_EXT);
    assign overflow      = ovf_q;
    assign data_len      = len_q;

endmodule

// File: tb/tb_m_axis_packet_tx.sv
// Bench for m_axis_packet_tx with a 16-byte buffer. A byte-queue model holds
// the packet as written; expected beats are derived from byte positions.

module tb_m_axis_packet_tx;

    localparam int FS = 16;
    localparam int LW = 8;

    logic          aclk;
    logic          aresetn;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          commit;
    logic          abort;
    logic          ready;
    logic          overflow;
    logic [LW-1:0] data_len;
    logic [31:0]   m_axis_tdata;
    logic [3:0]    m_axis_tkeep;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] model_q [$];

    m_axis_packet_tx #(.FIFO_SIZE(FS), .LEN_WIDTH(LW)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .commit        (commit),
        .abort         (abort),
        .ready         (ready),
        .overflow      (overflow),
        .data_len      (data_len),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // Writes one byte; the model keeps it only if the buffer has room.
    task automatic write_byte(input logic [7:0] b);
        logic exp_ovf;
        exp_ovf = (model_q.size() >= FS);
        if (!exp_ovf) model_q.push_back(b);
        wr_en = 1'b1; wr_data = b;
        step();
        wr_en = 1'b0;
        n_cmp++;
        if (overflow !== exp_ovf) begin
            n_fail++; $display("FAIL write_overflow: got %b want %b", overflow, exp_ovf);
        end
        n_cmp++;
        if (data_len !== LW'(model_q.size())) begin
            n_fail++; $display("FAIL write_len: got %0d want %0d", data_len, model_q.size());
        end
        n_cmp++;
        if (ready !== (model_q.size() < FS)) begin
            n_fail++; $display("FAIL write_ready: got %b want %b", ready, model_q.size() < FS);
        end
    endtask

    task automatic do_commit();
        commit = 1'b1;
        step();
        commit = 1'b0;
    endtask

    // Streams the committed packet out and checks every cycle against the model.
    // mode 0: tready always 1; 1: random tready plus noise on write controls;
    // 2: tready pattern 1,0,0,1,0,1 repeating.
    task automatic drain(input int mode, input string name);
        int n, beats, idx, cyc;
        logic [31:0] exp_d;
        logic [3:0]  exp_k;
        logic        exp_l;
        logic        tr;
        int          pat [6] = '{1, 0, 0, 1, 0, 1};
        n = model_q.size();
        beats = (n + 3) / 4;
        idx = 0;
        cyc = 0;
        while (idx < beats && cyc < 400) begin
            exp_d = '0;
            exp_k = '0;
            for (int l = 0; l < 4; l++) begin
                if (4*idx + l < n) begin
                    exp_d[8*l +: 8] = model_q[4*idx + l];
                    exp_k[l] = 1'b1;
                end
            end
            exp_l = (idx == beats - 1);
            n_cmp++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_d || m_axis_tkeep !== exp_k ||
                m_axis_tlast !== exp_l) begin
                n_fail++;
                $display("FAIL %s_beat%0d: got v=%b d=%h k=%b l=%b want v=1 d=%h k=%b l=%b",
                         name, idx, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
                         exp_d, exp_k, exp_l);
            end
            n_cmp++;
            if (ready !== 1'b0 || data_len !== LW'(n) || overflow !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_send_status: got rdy=%b len=%0d ovf=%b want rdy=0 len=%0d ovf=0",
                         name, ready, data_len, overflow, n);
            end
            case (mode)
                0: tr = 1'b1;
                1: tr = ($urandom_range(0, 3) != 0);
                default: tr = pat[cyc % 6][0];
            endcase
            m_axis_tready = tr;
            if (mode == 1) begin
                wr_en = $urandom_range(0, 1); wr_data = 8'($urandom);
                commit = $urandom_range(0, 1); abort = $urandom_range(0, 1);
            end
            step();
            if (tr) idx++;
            cyc++;
        end
        m_axis_tready = 1'b0;
        wr_en = 1'b0; commit = 1'b0; abort = 1'b0;
        n_cmp++;
        if (idx != beats) begin
            n_fail++; $display("FAIL %s_timeout: got %0d beats want %0d", name, idx, beats);
        end
        n_cmp++;
        if (m_axis_tvalid !== 1'b0 || ready !== 1'b1 || data_len !== '0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_after: got v=%b rdy=%b len=%0d ovf=%b want v=0 rdy=1 len=0 ovf=0",
                     name, m_axis_tvalid, ready, data_len, overflow);
        end
        model_q.delete();
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        wr_en = 1'b0; wr_data = '0; commit = 1'b0; abort = 1'b0; m_axis_tready = 1'b0;
        repeat (2) step();
        n_cmp++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tkeep !== 4'b0 ||
            m_axis_tdata !== 32'h0 || overflow !== 1'b0 || ready !== 1'b1 || data_len !== '0) begin
            n_fail++;
            $display("FAIL reset: got v=%b l=%b k=%b d=%h ovf=%b rdy=%b len=%0d want 0/0/0/0/0/1/0",
                     m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata, overflow, ready, data_len);
        end
        aresetn = 1'b1;
        step();
    endtask

    task automatic test_basic();
        for (int i = 1; i <= 8; i++) write_byte(8'(i));
        do_commit();
        n_cmp++;
        if (m_axis_tdata !== 32'h04030201 || m_axis_tkeep !== 4'b1111 || m_axis_tlast !== 1'b0) begin
            n_fail++; $display("FAIL basic_first: got d=%h k=%b l=%b want 04030201/1111/0",
                               m_axis_tdata, m_axis_tkeep, m_axis_tlast);
        end
        drain(0, "basic");
    endtask

    task automatic test_partial();
        for (int len = 5; len <= 7; len++) begin
            for (int i = 0; i < len; i++) write_byte(8'hA0 + 8'(i));
            do_commit();
            drain(0, "partial");
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 13; i++) write_byte(8'($urandom));
        do_commit();
        drain(2, "stall");
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 17; i++) write_byte(8'h30 + 8'(i));
        step();
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_fail++; $display("FAIL overflow_pulse_width: got %b want 0", overflow);
        end
        do_commit();
        drain(0, "overflow");
    endtask

    task automatic test_abort();
        for (int i = 0; i < 3; i++) write_byte(8'h55);
        abort = 1'b1; wr_en = 1'b1; commit = 1'b1; wr_data = 8'h99;
        step();
        abort = 1'b0; wr_en = 1'b0; commit = 1'b0;
        model_q.delete();
        n_cmp++;
        if (data_len !== '0 || m_axis_tvalid !== 1'b0) begin
            n_fail++; $display("FAIL abort: got len=%0d v=%b want 0/0", data_len, m_axis_tvalid);
        end
        write_byte(8'h11);
        // Last byte written in the commit cycle must be part of the packet.
        model_q.push_back(8'h22);
        wr_en = 1'b1; wr_data = 8'h22; commit = 1'b1;
        step();
        wr_en = 1'b0; commit = 1'b0;
        n_cmp++;
        if (m_axis_tdata !== 32'h00002211 || m_axis_tkeep !== 4'b0011 || m_axis_tlast !== 1'b1) begin
            n_fail++; $display("FAIL abort_beat: got d=%h k=%b l=%b want 00002211/0011/1",
                               m_axis_tdata, m_axis_tkeep, m_axis_tlast);
        end
        drain(0, "abort");
        do_commit();
        repeat (2) begin
            n_cmp++;
            if (m_axis_tvalid !== 1'b0 || ready !== 1'b1) begin
                n_fail++; $display("FAIL empty_commit: got v=%b rdy=%b want 0/1", m_axis_tvalid, ready);
            end
            step();
        end
    endtask

    task automatic test_random();
        int len;
        for (int p = 0; p < 8; p++) begin
            len = $urandom_range(1, FS);
            for (int i = 0; i < len; i++) write_byte(8'($urandom));
            do_commit();
            drain(1, "random");
        end
    endtask

    task automatic test_reset_mid_send();
        for (int i = 0; i < 6; i++) write_byte(8'hC0 + 8'(i));
        do_commit();
        m_axis_tready = 1'b0;
        step();
        n_cmp++;
        if (m_axis_tvalid !== 1'b1) begin
            n_fail++; $display("FAIL midreset_pre: got v=%b want 1", m_axis_tvalid);
        end
        aresetn = 1'b0;
        #1;
        n_cmp++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tkeep !== 4'b0 || m_axis_tdata !== 32'h0) begin
            n_fail++; $display("FAIL midreset_async: got v=%b k=%b d=%h want 0/0/0",
                               m_axis_tvalid, m_axis_tkeep, m_axis_tdata);
        end
        #3;
        aresetn = 1'b1;
        model_q.delete();
        step();
        n_cmp++;
        if (m_axis_tvalid !== 1'b0 || ready !== 1'b1 || data_len !== '0) begin
            n_fail++; $display("FAIL midreset_after: got v=%b rdy=%b len=%0d want 0/1/0",
                               m_axis_tvalid, ready, data_len);
        end
        write_byte(8'h7E);
        do_commit();
        drain(0, "postreset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_partial();
        test_stall();
        test_overflow();
        test_abort();
        test_random();
        test_reset_mid_send();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
